// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
// Holds the 2-bit state encoding and the iteration-counter width helper.
package div_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OP   = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_OP   = ST_OP,
      S_FIX  = ST_FIX,
      S_DONE = ST_DONE
   } state_t;

   // Counter must be able to hold the value W itself (loaded at accept).
   function automatic int div_cbit(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration.
// Compares the already-shifted (W+1)-bit partial remainder against the
// divisor and subtracts when it fits; the quotient bit says whether it did.
module div_step #(
   parameter int W = 8
) (
   input  logic [W:0]   i_rem,
   input  logic [W-1:0] i_dvsr,
   output logic [W:0]   o_rem,
   output logic         o_qbit
);

   logic [W:0] w_dvsr_ext;
   logic [W:0] w_diff;

   assign w_dvsr_ext = {1'b0, i_dvsr};
   assign w_diff     = i_rem - w_dvsr_ext;

   // Unsigned (W+1)-bit compare; restore (keep i_rem) when the divisor does not fit.
   assign o_qbit = (i_rem >= w_dvsr_ext);
   assign o_rem  = o_qbit ? w_diff : i_rem;

endmodule

// File: rtl/div_seq.sv
// div_seq: parametrised sequential restoring divider, one quotient bit per cycle.
// Handshake: start accepted while ready; done_tick pulses when quo/rmd/dbz are valid.
// Optional signed mode is compiled in with the DIV_SIGNED_EN macro.
module div_seq
   import div_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sgn,
   input  logic [W-1:0] dvnd,
   input  logic [W-1:0] dvsr,
   output logic         ready,
   output logic         done_tick,
   output logic [W-1:0] quo,
   output logic [W-1:0] rmd,
   output logic         dbz
);

   localparam int CBIT = div_cbit(W);

   state_t          r_state;
   logic [CBIT-1:0] r_cnt;
   logic [W:0]      r_rem;      // widened so the shifted-in MSB is never lost
   logic [W-1:0]    r_dq;       // dividend shifts out, quotient shifts in
   logic [W-1:0]    r_dvsr;
   logic [W-1:0]    r_quo;
   logic [W-1:0]    r_rmd;
   logic            r_dbz;

   logic [W:0]      w_shift;
   logic [W:0]      w_step_rem;
   logic            w_qbit;
   logic [W-1:0]    w_dvnd_in;
   logic [W-1:0]    w_dvsr_in;
   logic [W-1:0]    w_quo_fix;
   logic [W-1:0]    w_rmd_fix;
   logic            w_unused_rem_msb;

   // Shift the remainder/dividend pair left by one before the compare.
   assign w_shift = {r_rem[W-1:0], r_dq[W-1]};

   div_step #(.W(W)) u_step (
      .i_rem  (w_shift),
      .i_dvsr (r_dvsr),
      .o_rem  (w_step_rem),
      .o_qbit (w_qbit)
   );

   // After a step the remainder is below the divisor, so its MSB is always clear.
   assign w_unused_rem_msb = r_rem[W];

`ifdef DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_dvnd_neg;
   logic w_dvsr_neg;

   assign w_dvnd_neg = sgn & dvnd[W-1];
   assign w_dvsr_neg = sgn & dvsr[W-1];

   // Magnitudes feed the unsigned core; most-negative maps onto itself,
   // which is the correct unsigned magnitude 2^(W-1).
   assign w_dvnd_in = w_dvnd_neg ? ({W{1'b0}} - dvnd) : dvnd;
   assign w_dvsr_in = w_dvsr_neg ? ({W{1'b0}} - dvsr) : dvsr;

   // Quotient truncates toward zero; remainder follows the dividend's sign.
   assign w_quo_fix = r_neg_q ? ({W{1'b0}} - r_dq) : r_dq;
   assign w_rmd_fix = r_neg_r ? ({W{1'b0}} - r_rem[W-1:0]) : r_rem[W-1:0];
`else
   logic w_unused_sgn;

   assign w_unused_sgn = sgn;
   assign w_dvnd_in    = dvnd;
   assign w_dvsr_in    = dvsr;
   assign w_quo_fix    = r_dq;
   assign w_rmd_fix    = r_rem[W-1:0];
`endif

   // Control FSM plus datapath and held result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dq    <= '0;
         r_dvsr  <= '0;
         r_quo   <= '0;
         r_rmd   <= '0;
         r_dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (dvsr == '0) begin
                     // Divide-by-zero short-cuts straight to DONE.
                     r_quo   <= '1;
                     r_rmd   <= dvnd;
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_rem   <= '0;
                     r_dq    <= w_dvnd_in;
                     r_dvsr  <= w_dvsr_in;
                     r_cnt   <= CBIT'(W);
`ifdef DIV_SIGNED_EN
                     r_neg_q <= w_dvnd_neg ^ w_dvsr_neg;
                     r_neg_r <= w_dvnd_neg;
`endif
                     r_state <= S_OP;
                  end
               end
            end
            S_OP: begin
               r_rem <= w_step_rem;
               r_dq  <= {r_dq[W-2:0], w_qbit};
               r_cnt <= r_cnt - CBIT'(1);
               if (r_cnt == CBIT'(1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_quo   <= w_quo_fix;
               r_rmd   <= w_rmd_fix;
               r_dbz   <= 1'b0;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready     = (r_state == S_IDLE);
   assign done_tick = (r_state == S_DONE);
   assign quo       = r_quo;
   assign rmd       = r_rmd;
   assign dbz       = r_dbz;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq at W=8 plus a W=16 back-to-back sweep.
// Signed expectations switch with DIV_SIGNED_EN.
module tb_div_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst8, start8, sgn8;
   logic [7:0]  dvnd8, dvsr8;
   logic        ready8, done8, dbz8;
   logic [7:0]  quo8, rmd8;

   logic        rst16, start16, sgn16;
   logic [15:0] dvnd16, dvsr16;
   logic        ready16, done16, dbz16;
   logic [15:0] quo16, rmd16;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   div_seq #(.W(8)) u_dut8 (
      .clk(clk), .rst(rst8), .start(start8), .sgn(sgn8),
      .dvnd(dvnd8), .dvsr(dvsr8), .ready(ready8), .done_tick(done8),
      .quo(quo8), .rmd(rmd8), .dbz(dbz8)
   );

   div_seq #(.W(16)) u_dut16 (
      .clk(clk), .rst(rst16), .start(start16), .sgn(sgn16),
      .dvnd(dvnd16), .dvsr(dvsr16), .ready(ready16), .done_tick(done16),
      .quo(quo16), .rmd(rmd16), .dbz(dbz16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Wait for ready at a falling edge, present operands, let the next rising edge accept.
   task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic s);
      int guard;
      guard = 0;
      @(negedge clk);
      while (ready8 !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", 32'(ready8), 32'd1);
      dvnd8  = a;
      dvsr8  = b;
      sgn8   = s;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
   endtask

   // Latency 1 means done_tick is already high just after the accepting edge.
   task automatic wait_done8(output int lat, output int rdy_seen);
      lat      = 1;
      rdy_seen = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         if (ready8) rdy_seen++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] eq, input logic [7:0] er,
                       input logic ez, input int elat);
      int lat, rs;
      accept8(a, b, s);
      wait_done8(lat, rs);
      check({tag, "_lat"}, 32'(lat), 32'(elat));
      check({tag, "_quo"}, 32'(quo8), 32'(eq));
      check({tag, "_rmd"}, 32'(rmd8), 32'(er));
      check({tag, "_dbz"}, 32'(dbz8), 32'(ez));
      check({tag, "_rdylow"}, 32'(rs), 32'd0);
      $display("div8 %s: %0d/%0d sgn=%0d -> quo=0x%0h rmd=0x%0h dbz=%0d lat=%0d",
               tag, a, b, s, quo8, rmd8, dbz8, lat);
   endtask

   logic [15:0] exp_q16[$];
   logic [15:0] exp_r16[$];

   initial begin
      int lat, rs, nd, issued, ndone, guard, prev;
      logic [15:0] a16, b16, eq, er;

      rst8 = 1'b1; start8 = 1'b0; sgn8 = 1'b0; dvnd8 = '0; dvsr8 = '0;
      rst16 = 1'b1; start16 = 1'b0; sgn16 = 1'b0; dvnd16 = '0; dvsr16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready8), 32'd1);
      check("rst_done",  32'(done8),  32'd0);
      check("rst_quo",   32'(quo8),   32'd0);
      check("rst_rmd",   32'(rmd8),   32'd0);
      check("rst_dbz",   32'(dbz8),   32'd0);
      check("rst16_ready", 32'(ready16), 32'd1);
      @(negedge clk);
      rst8  = 1'b0;
      rst16 = 1'b0;

      // Basic and widened-remainder cases.
      run8("u200_7",   8'd200, 8'd7,   1'b0, 8'd28,  8'd4, 1'b0, 10);
      run8("u255_1",   8'd255, 8'd1,   1'b0, 8'd255, 8'd0, 1'b0, 10);
      run8("u255_255", 8'd255, 8'd255, 1'b0, 8'd1,   8'd0, 1'b0, 10);
      run8("u3_200",   8'd3,   8'd200, 1'b0, 8'd0,   8'd3, 1'b0, 10);

      // Divide by zero, then a normal op clears the flag.
      run8("dbz57",    8'd57,  8'd0,   1'b0, 8'hFF,  8'd57, 1'b1, 1);
      run8("u10_3",    8'd10,  8'd3,   1'b0, 8'd3,   8'd1,  1'b0, 10);

      // start with new operands during OP is ignored; old result held meanwhile.
      accept8(8'd50, 8'd5, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      dvnd8 = 8'd99; dvsr8 = 8'd2; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      check("ign_hold_quo", 32'(quo8), 32'd3);
      check("ign_busy", 32'(ready8), 32'd0);
      wait_done8(lat, rs);
      check("ign_lat", 32'(lat + 3), 32'd10);
      check("ign_quo", 32'(quo8), 32'd10);
      check("ign_rmd", 32'(rmd8), 32'd0);
      $display("div8 ign: 50/5 with mid-op start 99/2 -> quo=%0d rmd=%0d", quo8, rmd8);

`ifdef DIV_SIGNED_EN
      run8("s_m7_2",    8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 10);
      run8("s_7_m2",    8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 10);
      run8("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 10);
`else
      // Without signed support, sgn is ignored and operands are unsigned.
      run8("s_m7_2",    8'hF9, 8'h02, 1'b1, 8'h7C, 8'h01, 1'b0, 10);
      run8("s_7_m2",    8'h07, 8'hFE, 1'b1, 8'h00, 8'h07, 1'b0, 10);
      run8("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 10);
`endif

      // Reset in the middle of an operation.
      accept8(8'd200, 8'd7, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst8 = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_ready", 32'(ready8), 32'd1);
      check("mrst_done",  32'(done8),  32'd0);
      check("mrst_quo",   32'(quo8),   32'd0);
      check("mrst_rmd",   32'(rmd8),   32'd0);
      check("mrst_dbz",   32'(dbz8),   32'd0);
      @(negedge clk);
      rst8 = 1'b0;
      nd = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done8) nd++;
      end
      check("mrst_nodone", 32'(nd), 32'd0);
      $display("div8 mrst: reset mid-op, done pulses afterwards=%0d", nd);
      run8("u100_9", 8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 10);

      // W=16 sweep with start held high while there is work to issue.
      issued = 0; ndone = 0; guard = 0; prev = -1;
      while (ndone < 1000 && guard < 25000) begin
         @(negedge clk);
         guard++;
         if (done16) begin
            check("sweep_pending", 32'(exp_q16.size() > 0), 32'd1);
            if (exp_q16.size() > 0) begin
               eq = exp_q16.pop_front();
               er = exp_r16.pop_front();
               check("sweep_quo", 32'(quo16), 32'(eq));
               check("sweep_rmd", 32'(rmd16), 32'(er));
               check("sweep_dbz", 32'(dbz16), 32'd0);
            end
            if (prev >= 0) check("sweep_gap", 32'(cyc - prev), 32'd19);
            prev = cyc;
            ndone++;
         end
         if (ready16) begin
            if (issued < 1000) begin
               a16 = 16'($urandom);
               if (issued % 4 == 0) b16 = 16'($urandom_range(1, 15));
               else                 b16 = 16'($urandom_range(1, 65535));
               dvnd16  = a16;
               dvsr16  = b16;
               start16 = 1'b1;
               exp_q16.push_back(a16 / b16);
               exp_r16.push_back(a16 % b16);
               issued++;
            end else begin
               start16 = 1'b0;
            end
         end
      end
      check("sweep_count", 32'(ndone), 32'd1000);
      $display("div16 sweep: issued=%0d completed=%0d", issued, ndone);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
